// File: rtl/board_io_ctrl_if.sv
// Pin-side bundle of the board I/O controller: raw buttons, debounced button
// status, LED configuration strobe and the RGB PWM outputs.
interface board_io_ctrl_if #(
    parameter int NUM_BTNS = 2,
    parameter int NUM_LEDS = 2,
    parameter int PWM_BITS = 8
);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [NUM_BTNS-1:0]   btn_i;
    logic [NUM_BTNS-1:0]   btn_level_o;
    logic [NUM_BTNS-1:0]   btn_press_o;
    logic [NUM_BTNS-1:0]   btn_release_o;
    logic                  led_cfg_we_i;
    logic [IDX_W-1:0]      led_cfg_idx_i;
    logic [1:0]            led_cfg_mode_i;
    logic [3*PWM_BITS-1:0] led_cfg_rgb_i;
    logic [NUM_LEDS-1:0]   led_r_o;
    logic [NUM_LEDS-1:0]   led_g_o;
    logic [NUM_LEDS-1:0]   led_b_o;

    modport master (
        output btn_i,
        output led_cfg_we_i,
        output led_cfg_idx_i,
        output led_cfg_mode_i,
        output led_cfg_rgb_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_release_o,
        input  led_r_o,
        input  led_g_o,
        input  led_b_o
    );

    modport slave (
        input  btn_i,
        input  led_cfg_we_i,
        input  led_cfg_idx_i,
        input  led_cfg_mode_i,
        input  led_cfg_rgb_i,
        output btn_level_o,
        output btn_press_o,
        output btn_release_o,
        output led_r_o,
        output led_g_o,
        output led_b_o
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced push-buttons with press/release pulses and
// PWM-driven RGB LEDs with off/solid/blink/breathe modes.
module board_io_ctrl #(
    parameter int NUM_BTNS        = 2,
    parameter int NUM_LEDS        = 2,
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int BLINK_DIV_BITS  = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    board_io_ctrl_if.slave io
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_SOLID   = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic [0:0] RAMP_UP   = 1'b0;
    localparam logic [0:0] RAMP_DOWN = 1'b1;

    logic [NUM_BTNS-1:0] sync_1;
    logic [NUM_BTNS-1:0] sync_2;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic [DB_W-1:0]     db_cnt [NUM_BTNS];

    logic [1:0]          led_mode [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_r   [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_g   [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_b   [NUM_LEDS];

    logic [PWM_BITS-1:0]       pwm_cnt;
    logic [PWM_BITS-1:0]       ramp;
    logic [0:0]                ramp_dir;
    logic [BLINK_DIV_BITS-1:0] blink_cnt;
    logic                      blink_off;

    logic [NUM_LEDS-1:0] r_on;
    logic [NUM_LEDS-1:0] g_on;
    logic [NUM_LEDS-1:0] b_on;
    logic [NUM_LEDS-1:0] led_r;
    logic [NUM_LEDS-1:0] led_g;
    logic [NUM_LEDS-1:0] led_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= io.btn_i;
            sync_2 <= sync_1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BTNS; b++) begin
                db_cnt[b] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int b = 0; b < NUM_BTNS; b++) begin
                btn_press[b]   <= 1'b0;
                btn_release[b] <= 1'b0;
                if (sync_2[b] == btn_level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db_cnt[b]      <= '0;
                    btn_level[b]   <= ~btn_level[b];
                    btn_press[b]   <= ~btn_level[b];
                    btn_release[b] <= btn_level[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign io.btn_level_o   = btn_level;
    assign io.btn_press_o   = btn_press;
    assign io.btn_release_o = btn_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_mode[i] <= MODE_OFF;
                duty_r[i]   <= '0;
                duty_g[i]   <= '0;
                duty_b[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (io.led_cfg_we_i && (io.led_cfg_idx_i == IDX_W'(i))) begin
                    led_mode[i] <= io.led_cfg_mode_i;
                    duty_r[i]   <= io.led_cfg_rgb_i[3*PWM_BITS-1:2*PWM_BITS];
                    duty_g[i]   <= io.led_cfg_rgb_i[2*PWM_BITS-1:PWM_BITS];
                    duty_b[i]   <= io.led_cfg_rgb_i[PWM_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Triangle ramp advances once per PWM period; each endpoint is held for one extra period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp     <= '0;
            ramp_dir <= RAMP_UP;
        end else if (pwm_cnt == PWM_MAX) begin
            if (ramp_dir == RAMP_UP) begin
                if (ramp == PWM_MAX) begin
                    ramp_dir <= RAMP_DOWN;
                end else begin
                    ramp <= ramp + 1'b1;
                end
            end else begin
                if (ramp == '0) begin
                    ramp_dir <= RAMP_UP;
                end else begin
                    ramp <= ramp - 1'b1;
                end
            end
        end
    end

    assign blink_off = blink_cnt[BLINK_DIV_BITS-1];

    function automatic logic [PWM_BITS-1:0] eff_duty(
        input logic [1:0]          mode,
        input logic [PWM_BITS-1:0] duty,
        input logic                blank,
        input logic [PWM_BITS-1:0] level
    );
        logic [2*PWM_BITS-1:0] prod;
        logic [PWM_BITS-1:0]   result;
        prod = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, level};
        case (mode)
            MODE_OFF:     result = '0;
            MODE_SOLID:   result = duty;
            MODE_BLINK:   result = blank ? '0 : duty;
            MODE_BREATHE: result = PWM_BITS'(prod >> PWM_BITS);
            default:      result = '0;
        endcase
        return result;
    endfunction

    always_comb begin
        r_on = '0;
        g_on = '0;
        b_on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            r_on[i] = pwm_cnt < eff_duty(led_mode[i], duty_r[i], blink_off, ramp);
            g_on[i] = pwm_cnt < eff_duty(led_mode[i], duty_g[i], blink_off, ramp);
            b_on[i] = pwm_cnt < eff_duty(led_mode[i], duty_b[i], blink_off, ramp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= '0;
            led_g <= '0;
            led_b <= '0;
        end else begin
            led_r <= r_on;
            led_g <= g_on;
            led_b <= b_on;
        end
    end

    assign io.led_r_o = led_r;
    assign io.led_g_o = led_g;
    assign io.led_b_o = led_b;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: expected values are queued as stimulus is
// applied and popped when the matching DUT observation completes.
module tb_board_io_ctrl;

    localparam int NB = 2;
    localparam int NL = 2;
    localparam int PB = 4;
    localparam int DB = 4;
    localparam int BD = 6;

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_SOLID   = 2'b01;
    localparam logic [1:0] M_BLINK   = 2'b10;
    localparam logic [1:0] M_BREATHE = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    board_io_ctrl_if #(.NUM_BTNS(NB), .NUM_LEDS(NL), .PWM_BITS(PB)) io ();

    board_io_ctrl #(
        .NUM_BTNS(NB),
        .NUM_LEDS(NL),
        .PWM_BITS(PB),
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIV_BITS(BD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int exp_q [$];
    string tag_q [$];
    int press_seen [NB] = '{default: 0};
    int rel_seen   [NB] = '{default: 0};
    int k, rc, gc, bc, zr, snap, p;

    // Rising edges since the last reset release; the DUT's free-running counters start together with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic popCheck(input int observed);
        string t;
        int e;
        if (exp_q.size() == 0) begin
            checkOutput("sb_underflow", exp_q.size(), 1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            checkOutput(t, observed, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            press_seen[b] += int'(io.btn_press_o[b]);
            rel_seen[b]   += int'(io.btn_release_o[b]);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [1:0] mode, input int r, input int g, input int b);
        io.led_cfg_idx_i  = 1'(idx);
        io.led_cfg_mode_i = mode;
        io.led_cfg_rgb_i  = {4'(r), 4'(g), 4'(b)};
        io.led_cfg_we_i   = 1'b1;
        tick();
        io.led_cfg_we_i   = 1'b0;
    endtask

    task automatic countOn(input int n, input int led, output int r_cnt, output int g_cnt,
                           output int b_cnt, output int zrun);
        int run;
        run = 0;
        r_cnt = 0; g_cnt = 0; b_cnt = 0; zrun = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            r_cnt += int'(io.led_r_o[led]);
            g_cnt += int'(io.led_g_o[led]);
            b_cnt += int'(io.led_b_o[led]);
            if (io.led_r_o[led]) run = 0;
            else begin
                run++;
                if (run > zrun) zrun = run;
            end
        end
    endtask

    task automatic waitPulse(input int b, input bit rel, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(rel ? io.btn_release_o[b] : io.btn_press_o[b]) && lat < 30);
    endtask

    function automatic int triRamp(input int period);
        int q;
        q = period % 32;
        return (q < 16) ? q : 31 - q;
    endfunction

    initial begin
        io.btn_i          = '0;
        io.led_cfg_we_i   = 1'b0;
        io.led_cfg_idx_i  = '0;
        io.led_cfg_mode_i = M_OFF;
        io.led_cfg_rgb_i  = '0;
        repeat (3) tick();
        pushExpect("reset_outputs", 0);
        popCheck(int'({io.btn_level_o, io.btn_press_o, io.btn_release_o,
                       io.led_r_o, io.led_g_o, io.led_b_o}));
        rst_n = 1'b1;
        repeat (2) tick();

        snap = press_seen[0];
        pushExpect("bounce_press", 0);
        for (int t = 0; t < 20; t++) begin
            io.btn_i[0] = (t % 2 == 0);
            repeat (2) tick();
        end
        popCheck(press_seen[0] - snap);

        io.btn_i[0] = 1'b1;
        snap = press_seen[0];
        pushExpect("press_latency", 6);
        waitPulse(0, 1'b0, k);
        popCheck(k);
        repeat (10) tick();
        pushExpect("press_count", 1);
        popCheck(press_seen[0] - snap);
        pushExpect("level_after_press", 1);
        popCheck(int'(io.btn_level_o[0]));

        snap = rel_seen[0];
        io.btn_i[0] = 1'b0;
        repeat (3) tick();
        io.btn_i[0] = 1'b1;
        pushExpect("glitch_release", 0);
        pushExpect("level_after_glitch", 1);
        repeat (20) tick();
        popCheck(rel_seen[0] - snap);
        popCheck(int'(io.btn_level_o[0]));

        io.btn_i[0] = 1'b0;
        pushExpect("release_latency", 6);
        waitPulse(0, 1'b1, k);
        popCheck(k);
        tick();
        pushExpect("level_after_release", 0);
        popCheck(int'(io.btn_level_o[0]));
        pushExpect("btn1_pulses", 0);
        popCheck(press_seen[1] + rel_seen[1]);

        applyStimulus(0, M_SOLID, 4, 0, 15);
        repeat (2) tick();
        pushExpect("solid_r", 8);
        pushExpect("solid_g", 0);
        pushExpect("solid_b", 30);
        countOn(32, 0, rc, gc, bc, zr);
        popCheck(rc);
        popCheck(gc);
        popCheck(bc);
        pushExpect("led1_off", 0);
        countOn(32, 1, rc, gc, bc, zr);
        popCheck(rc + gc + bc);

        applyStimulus(1, M_BLINK, 15, 0, 0);
        repeat (2) tick();
        pushExpect("blink_r64", 30);
        pushExpect("blink_g64", 0);
        countOn(64, 1, rc, gc, bc, zr);
        popCheck(rc);
        popCheck(gc + bc);
        pushExpect("blink_dark_run", 33);
        countOn(96, 1, rc, gc, bc, zr);
        popCheck(zr);

        applyStimulus(0, M_BREATHE, 15, 0, 0);
        for (int w = 0; w < 20 && (edges % 16) != 0; w++) tick();
        for (int n = 0; n < 40; n++) begin
            p = edges / 16;
            pushExpect("breathe_period", (15 * triRamp(p)) >> 4);
            countOn(16, 0, rc, gc, bc, zr);
            popCheck(rc);
        end

        applyStimulus(0, M_SOLID, 15, 15, 15);
        io.btn_i[0] = 1'b1;
        repeat (12) tick();
        pushExpect("pre_reset_level", 1);
        popCheck(int'(io.btn_level_o[0]));
        for (int w = 0; w < 20 && !io.led_r_o[0]; w++) tick();
        #2 rst_n = 1'b0;
        #1;
        pushExpect("async_reset_outputs", 0);
        popCheck(int'({io.btn_level_o, io.btn_press_o, io.btn_release_o,
                       io.led_r_o, io.led_g_o, io.led_b_o}));
        @(negedge clk);
        rst_n = 1'b1;
        pushExpect("held_press_latency", 6);
        waitPulse(0, 1'b0, k);
        popCheck(k);
        pushExpect("leds_off_after_reset", 0);
        snap = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            snap += $countones({io.led_r_o, io.led_g_o, io.led_b_o});
        end
        popCheck(snap);

        checkOutput("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
